// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-master round-robin sequencer for a single-port,
// byte-addressed, big-endian 32-bit data RAM (active-low nRD/nWR,
// combinational read, write on the CLK negedge).
// Master 0 is instruction fetch; master 1 is the load/store unit.
// Optional feature: define RAM_ARB_BOUNDS_CHECK_EN to suppress RAM strobes
// for out-of-range words and flag err alongside the ack.
//
// Handshake: a master raises mN_req with we/addr/wdata stable and holds it
// until mN_ack. Request fields are latched on grant, and later changes are
// ignored until the transaction completes. mN_ack is a one-cycle pulse in
// DONE, and mN_rdata is valid in that cycle. A request still high in the
// IDLE cycle after the ack counts as a new request.
module ram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_BYTES   = 61
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_nRD,
  output logic        ram_nWR,
  input  logic [31:0] ram_dout,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

`ifdef RAM_ARB_BOUNDS_CHECK_EN
  localparam logic BOUNDS_EN = 1'b1;
`else
  localparam logic BOUNDS_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic        oob_q, oob_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        gnt_id;
  logic [31:0] sel_addr;
  logic [31:0] cap_data;

  // State register: all flops, synchronous reset (m0 wins the first tie).
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      oob_q      <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      id_q       <= id_d;
      last_q     <= last_d;
      oob_q      <= oob_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next state: round-robin grant in IDLE, wait countdown in ACCESS, read capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    last_d     = last_q;
    oob_d      = oob_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    gnt_id     = 1'b0;
    sel_addr   = 32'd0;
    cap_data   = 32'd0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not served last wins.
          gnt_id   = (m0_req && m1_req) ? ~last_q : m1_req;
          sel_addr = gnt_id ? m1_addr : m0_addr;
          we_d     = gnt_id ? m1_we : m0_we;
          wdata_d  = gnt_id ? m1_wdata : m0_wdata;
          addr_d   = sel_addr;
          id_d     = gnt_id;
          last_d   = gnt_id;
          cnt_d    = CNT_INIT;
          // The last byte of the aligned word must fall inside the RAM.
          oob_d    = BOUNDS_EN & ({2'b00, sel_addr | 32'h3} >= 34'(RAM_BYTES));
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = DONE;
          cap_data = oob_q ? 32'd0 : ram_dout;
          if (!we_q || oob_q) begin
            if (id_q) m1_rdata_d = cap_data;
            else      m0_rdata_d = cap_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM strobes decoded from state so a reset releases them at once.
  always_comb begin
    ram_addr = 32'd0;
    ram_din  = 32'd0;
    ram_nRD  = 1'b1;
    ram_nWR  = 1'b1;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    busy     = 1'b0;
    err      = 1'b0;
    case (state_q)
      ACCESS: begin
        busy     = 1'b1;
        ram_addr = addr_q & 32'hFFFF_FFFC;
        ram_din  = wdata_q;
        if (!oob_q) begin
          // A write strobes only in the last cycle: one negedge, never partial.
          if (we_q) ram_nWR = (cnt_q != 4'd0);
          else      ram_nRD = 1'b0;
        end
      end
      DONE: begin
        busy   = 1'b1;
        m0_ack = ~id_q;
        m1_ack = id_q;
        err    = oob_q;
      end
      default: ;
    endcase
  end

  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance 0 with WAIT_CYCLES=1, instance 1 with
// WAIT_CYCLES=3, each with its own big-endian byte RAM model.
module tb_ram_port_arbiter;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [31:0] rdata [2][2];
  logic        ack   [2][2];
  logic [31:0] ram_addr [2];
  logic [31:0] ram_din  [2];
  logic [31:0] ram_dout [2];
  logic        nrd  [2];
  logic        nwr  [2];
  logic        busy [2];
  logic        err  [2];
  logic [1:0]  dbg  [2];

  logic [7:0]  mem [2][64];
  logic        bk_go;
  int          bk_i;
  logic [5:0]  bk_a;
  logic [31:0] bk_d;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  ram_port_arbiter #(.WAIT_CYCLES(1), .RAM_BYTES(61)) u_a (
    .CLK(clk), .Reset(rst),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_rdata(rdata[0][0]), .m0_ack(ack[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_rdata(rdata[0][1]), .m1_ack(ack[0][1]),
    .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_nRD(nrd[0]), .ram_nWR(nwr[0]),
    .ram_dout(ram_dout[0]), .busy(busy[0]), .err(err[0]), .dbg_state(dbg[0])
  );

  ram_port_arbiter #(.WAIT_CYCLES(3), .RAM_BYTES(61)) u_b (
    .CLK(clk), .Reset(rst),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_rdata(rdata[1][0]), .m0_ack(ack[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_rdata(rdata[1][1]), .m1_ack(ack[1][1]),
    .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_nRD(nrd[1]), .ram_nWR(nwr[1]),
    .ram_dout(ram_dout[1]), .busy(busy[1]), .err(err[1]), .dbg_state(dbg[1])
  );

  // RAM model: combinational big-endian read, marker value when not reading.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [5:0] wa;
    assign wa = {ram_addr[g][5:2], 2'b00};
    assign ram_dout[g] = nrd[g] ? 32'h5A5A_5A5A :
                         {mem[g][wa], mem[g][wa + 6'd1], mem[g][wa + 6'd2], mem[g][wa + 6'd3]};
  end

  // RAM model: write on negedge while nWR is low, plus a bench preload port.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!nwr[i])
        for (int k = 0; k < 4; k++)
          mem[i][{ram_addr[i][5:2], 2'(k)}] <= ram_din[i][31 - 8*k -: 8];
    if (bk_go)
      for (int k = 0; k < 4; k++)
        mem[bk_i][{bk_a[5:2], 2'(k)}] <= bk_d[31 - 8*k -: 8];
  end

  function automatic logic [31:0] mem_word(input int i, input logic [31:0] a);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    return {mem[i][b], mem[i][b + 6'd1], mem[i][b + 6'd2], mem[i][b + 6'd3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int i, input logic [31:0] a, input logic [31:0] d);
    bk_i  = i;
    bk_a  = a[5:0];
    bk_d  = d;
    bk_go = 1'b1;
    @(negedge clk);
    #1;
    bk_go = 1'b0;
  endtask

  // One transaction from master m of instance i; returns data and strobe statistics.
  task automatic xact(input int i, input int m, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat,
                      output int nr, output int nw, output logic [31:0] a_seen,
                      output logic e_seen);
    req[i][m]   = 1'b1;
    we[i][m]    = w;
    addr[i][m]  = a;
    wdata[i][m] = wd;
    rd = 32'hFFFF_FFFF; lat = 0; nr = 0; nw = 0; a_seen = 32'hFFFF_FFFF; e_seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (!nrd[i]) nr++;
      if (!nwr[i]) nw++;
      if (c == 1) a_seen = ram_addr[i];
      check("no_other_ack", 32'(ack[i][1-m]), 32'd0);
      if (ack[i][m]) begin
        lat = c; rd = rdata[i][m]; e_seen = err[i];
        break;
      end
    end
    req[i][m] = 1'b0;
    tick();
  endtask

  logic [31:0] rd, as_seen, got;
  int          lat, nr, nw, n_ack, n_w;
  logic        es;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bk_go = 1'b0; bk_i = 0; bk_a = '0; bk_d = '0;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; we[i][m] = 1'b0; addr[i][m] = '0; wdata[i][m] = '0;
      end
    tick(); tick();

    // Reset state
    check("rst_nrd",    32'(nrd[0]), 32'd1);
    check("rst_nwr",    32'(nwr[0]), 32'd1);
    check("rst_addr",   ram_addr[0], 32'd0);
    check("rst_din",    ram_din[0], 32'd0);
    check("rst_rdata0", rdata[0][0], 32'd0);
    check("rst_rdata1", rdata[0][1], 32'd0);
    check("rst_ack",    32'({ack[0][0], ack[0][1]}), 32'd0);
    check("rst_busy",   32'(busy[0]), 32'd0);
    check("rst_err",    32'(err[0]), 32'd0);
    check("rst_state",  32'(dbg[0]), 32'd0);
    check("rst_b_nrd",  32'(nrd[1]), 32'd1);
    rst = 1'b0;
    tick();

    preload(0, 32'h08, 32'h1122_3344);
    preload(0, 32'h04, 32'hA1B2_C3D4);
    preload(0, 32'h3C, 32'h0BAD_0BAD);
    preload(0, 32'h38, 32'h0000_0000);
    preload(1, 32'h04, 32'h0102_0304);
    tick();

    // Basic read: ack two cycles after the request
    xact(0, 0, 1'b0, 32'h08, 32'h0, rd, lat, nr, nw, as_seen, es);
    check("t1_lat",   lat, 2);
    check("t1_rdata", rd, 32'h1122_3344);
    check("t1_nrd",   nr, 1);
    check("t1_nwr",   nw, 0);

    // Write then read back
    xact(0, 1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat, nr, nw, as_seen, es);
    check("t2_wr_lat",  lat, 2);
    check("t2_wr_nwr",  nw, 1);
    check("t2_wr_nrd",  nr, 0);
    check("t2_wr_err",  32'(es), 32'd0);
    check("t2_wr_mem",  mem_word(0, 32'h10), 32'hDEAD_BEEF);
    xact(0, 1, 1'b0, 32'h10, 32'h0, rd, lat, nr, nw, as_seen, es);
    check("t2_rd_data", rd, 32'hDEAD_BEEF);
    check("t2_rd_nwr",  nw, 0);
    check("t2_m0_hold", rdata[0][0], 32'h1122_3344);

    // Misaligned read is forced down to the word
    xact(0, 0, 1'b0, 32'h06, 32'h0, rd, lat, nr, nw, as_seen, es);
    check("t5_ram_addr", as_seen, 32'h04);
    check("t5_rdata",    rd, 32'hA1B2_C3D4);
    check("t5_m1_hold",  rdata[0][1], 32'hDEAD_BEEF);

    // Word at 0x3C ends at byte 63, beyond a 61-byte RAM
    xact(0, 1, 1'b1, 32'h3C, 32'h1234_5678, rd, lat, nr, nw, as_seen, es);
    check("t6_oob_lat", lat, 2);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    check("t6_oob_nwr", nw, 0);
    check("t6_oob_err", 32'(es), 32'd1);
    check("t6_oob_mem", mem_word(0, 32'h3C), 32'h0BAD_0BAD);
`else
    check("t6_oob_nwr", nw, 1);
    check("t6_oob_err", 32'(es), 32'd0);
    check("t6_oob_mem", mem_word(0, 32'h3C), 32'h1234_5678);
`endif
    xact(0, 0, 1'b0, 32'h3C, 32'h0, rd, lat, nr, nw, as_seen, es);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    check("t6_oob_rd",  rd, 32'h0);
    check("t6_oob_nrd", nr, 0);
`else
    check("t6_oob_rd",  rd, 32'h1234_5678);
    check("t6_oob_nrd", nr, 1);
`endif
    xact(0, 1, 1'b1, 32'h38, 32'h55AA_55AA, rd, lat, nr, nw, as_seen, es);
    check("t6_in_nwr", nw, 1);
    check("t6_in_err", 32'(es), 32'd0);
    check("t6_in_mem", mem_word(0, 32'h38), 32'h55AA_55AA);

    // Both masters request together from reset and hold: m0, m1, m0, m1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.push_back({24'd2,  8'd0});
    exp_q.push_back({24'd5,  8'd1});
    exp_q.push_back({24'd8,  8'd0});
    exp_q.push_back({24'd11, 8'd1});
    addr[0][0] = 32'h08; we[0][0] = 1'b0;
    addr[0][1] = 32'h10; we[0][1] = 1'b0;
    req[0][0] = 1'b1; req[0][1] = 1'b1;
    n_ack = 0;
    for (int c = 1; c <= 20 && n_ack < 4; c++) begin
      tick();
      check("t3_dual_ack", 32'(ack[0][0] & ack[0][1]), 32'd0);
      if (ack[0][0] || ack[0][1]) begin
        got = {24'(c), 7'd0, ack[0][1]};
        check("t3_grant", got, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF);
        n_ack++;
      end
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    check("t3_ack_count", n_ack, 4);
    check("t3_m0_data", rdata[0][0], 32'h1122_3344);
    check("t3_m1_data", rdata[0][1], 32'hDEAD_BEEF);
    tick(); tick();

    // WAIT_CYCLES=3 read latency
    xact(1, 0, 1'b0, 32'h04, 32'h0, rd, lat, nr, nw, as_seen, es);
    check("t4_rd_lat",   lat, 4);
    check("t4_rd_nrd",   nr, 3);
    check("t4_rd_data",  rd, 32'h0102_0304);

    // Reset during the first ACCESS cycle of a write: no write, no ack
    addr[1][1] = 32'h04; we[1][1] = 1'b1; wdata[1][1] = 32'hCAFE_F00D;
    req[1][1] = 1'b1;
    tick();
    check("t4_busy", 32'(busy[1]), 32'd1);
    n_w = (nwr[1] == 1'b0) ? 1 : 0;
    rst = 1'b1;
    req[1][1] = 1'b0;
    n_ack = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        check("t4_abort_state", 32'(dbg[1]), 32'd0);
        check("t4_abort_busy",  32'(busy[1]), 32'd0);
        rst = 1'b0;
      end
      if (!nwr[1]) n_w++;
      if (ack[1][0] || ack[1][1]) n_ack++;
    end
    check("t4_nwr_never", n_w, 0);
    check("t4_no_ack",    n_ack, 0);
    check("t4_mem",       mem_word(1, 32'h04), 32'h0102_0304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
